data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder that services the mem_read / mem_write strobes issued by the processor control path for lw/sw.
- Holds a word-addressed RAM. Accepts one request at a time and completes it after a programmable latency.
- Returns load data with a one-cycle ready pulse, and flags misaligned or out-of-range accesses.
- Sits between the datapath ALU address output (alu_src=1 path) and the register write-back mux.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 256, number of words in the array; must be a power of 2.
- LATENCY, 2, cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  load request level from the control path.
- mem_write  input  1  store request level from the control path.
- addr  input  32  byte address, taken from the ALU result.
- write_data  input  DATA_W  store data (rs2 value).
- read_data  output  DATA_W  load result; holds its value between loads.
- ready  output  1  one-cycle pulse when a request completes, including error completions.
- busy  output  1  high from acceptance until the cycle ready is asserted, inclusive.
- err  output  1  one-cycle pulse, coincident with ready, for misaligned, out-of-range or conflicting requests.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - read_data=0, ready=0, busy=0, err=0, latency counter=0.
  - An in-flight store is dropped and the array is not written.
  - Array contents are not reset.
- IDLE:
  - A request is accepted on any edge where mem_read|mem_write=1.
  - On acceptance, latch op, addr, write_data and the error class. Set cnt=LATENCY-1 and go to WAIT.
  - busy rises in the cycle after acceptance.
- WAIT:
  - cnt decrements each cycle; when cnt=0, go to DONE.
  - Inputs are ignored while in WAIT, so changing addr or the strobes cannot affect the latched request.
  - With LATENCY=1, WAIT is skipped and the FSM goes IDLE to DONE directly.
- DONE (one cycle):
  - Perform the access and pulse ready, then return to IDLE.
  - Read: read_data gets mem[addr[log2(DEPTH)+1:2]].
  - Write: mem[index] gets write_data; read_data is unchanged.
- Timing:
  - ready is asserted exactly LATENCY cycles after the acceptance edge.
  - A request still held in the IDLE cycle after ready is accepted as a new request. Back-to-back throughput is therefore one access per LATENCY+1 cycles.
  - The requester must drop or change its strobes in the cycle ready is seen if it does not want a repeat.
- Errors, with priority conflict > misaligned > range:
  - conflict: mem_read=1 and mem_write=1 at acceptance.
  - misaligned: addr[1:0]!=0.
  - range: addr >= DEPTH*4.
  - On any error, complete with normal latency, pulse err with ready, do not touch the array, and leave read_data unchanged.
- Arithmetic:
  - The index uses the low address bits only after the range check passes. There is no wrap-around into the array.
  - The counter is 4 bits.
- Read-after-write to the same address in consecutive requests returns the new data, because the store commits in DONE before the next acceptance.

Decomposition:
- Shared package data_mem_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - err-class enum {NONE, CONFLICT, MISALIGN, RANGE}.
  - WORD_BYTES=4 and ADDR_LSB=2 constants.
- One sub-module, data_mem_array: single-port synchronous RAM (we, index, wdata, rdata), DATA_W x DEPTH.
- The FSM, counter and error classification stay in data_mem_responder.

Test Plan:
- Reset then idle: rst pulse mid-WAIT of a store to 0x10 -> ready never pulses; a later load of 0x10 returns the pre-store value; read_data=0 right after reset.
- Store then load, LATENCY=2: mem_write with addr=0x04, write_data=0xDEADBEEF -> ready exactly 2 cycles after acceptance; then mem_read addr=0x04 -> read_data=0xDEADBEEF on the ready cycle; busy is high for exactly 2 cycles per access.
- Misaligned: mem_read addr=0x06 -> ready and err pulse together; read_data keeps its previous value 0xDEADBEEF.
- Out of range with DEPTH=256: mem_write addr=0x400, data=0x1 -> err=1; a load of 0x000 is unchanged (no wrap-around write).
- Conflict: mem_read=mem_write=1, addr=0x08 -> err=1; word 0x08 is unchanged.
- Held strobe plus LATENCY=1: mem_read held high for 6 cycles at addr=0x0C -> ready pulses on cycles 1, 3 and 5 after the first acceptance; addr changes during WAIT (LATENCY=3 run) have no effect on the returned data.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM states, the error classes and the word-size constants.
package data_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    CONFLICT,
    MISALIGN,
    RANGE
  } err_t;

  // Conflict wins over misalignment, and misalignment wins over range.
  function automatic err_t classify(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] limit
  );
    if (rd && wr)
      return CONFLICT;
    else if (addr[1:0] != 2'b00)
      return MISALIGN;
    else if (addr >= limit)
      return RANGE;
    else
      return NONE;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM behind the responder.
// Both the write and the registered read happen on the rising edge.
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on we; the read port refreshes from the presented index every cycle.
  always_ff @(posedge clk) begin
    if (we)
      mem[index] <= wdata;
    rdata <= mem[index];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for lw/sw: one request in flight, fixed latency.
// Errors complete normally but never touch the array or read_data.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT    = 32'(DEPTH * WORD_BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  err_t              ecls;
  logic              op_wr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rdata;
  logic [IDX_W-1:0]  ram_idx;
  logic              accept;
  logic              do_rd;
  logic              we;

  assign accept = (state == IDLE) && (mem_read || mem_write);
  assign ready  = (state == DONE);
  assign busy   = (state != IDLE);
  assign err    = ready && (ecls != NONE);
  assign do_rd  = ready && !op_wr && (ecls == NONE);
  assign we     = ready && op_wr && (ecls == NONE);

  // Live address while idle so the RAM read starts at acceptance.
  assign ram_idx = (state == IDLE) ? addr[IDX_W+1:ADDR_LSB] : idx;

  // Load data is forwarded in the ready cycle, then held.
  assign read_data = do_rd ? rdata : hold;

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .index (ram_idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: count down in WAIT, single-cycle DONE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          cnt_n   = CNT_INIT;
          state_n = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture the request at acceptance; ignored inputs afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecls  <= NONE;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
    end else if (accept) begin
      ecls  <= classify(mem_read, mem_write, addr, LIMIT);
      op_wr <= mem_write;
      idx   <= addr[IDX_W+1:ADDR_LSB];
      wdata <= write_data;
    end
  end

  // Remember the last successful load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold <= '0;
    else if (do_rd)
      hold <= rdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at latencies 2, 1 and 3.
// Unit 0 uses LATENCY=2, unit 1 LATENCY=1, unit 2 LATENCY=3.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read   [3];
  logic        mem_write  [3];
  logic [31:0] addr       [3];
  logic [31:0] write_data [3];
  logic [31:0] read_data  [3];
  logic        ready      [3];
  logic        busy       [3];
  logic        err        [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_u
    localparam int L = (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    data_mem_responder #(
      .DATA_W  (32),
      .DEPTH   (256),
      .LATENCY (L)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read[i]),
      .mem_write  (mem_write[i]),
      .addr       (addr[i]),
      .write_data (write_data[i]),
      .read_data  (read_data[i]),
      .ready      (ready[i]),
      .busy       (busy[i]),
      .err        (err[i])
    );
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: a2 replaces addr right after acceptance.
  task automatic access(
    input  int          u,
    input  bit          rd,
    input  bit          wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [31:0] a2,
    output int          lat,
    output bit          e,
    output logic [31:0] rdv,
    output int          nb
  );
    lat = 0;
    nb  = 0;
    e   = 1'b0;
    rdv = '0;
    @(negedge clk);
    mem_read[u]   = rd;
    mem_write[u]  = wr;
    addr[u]       = a;
    write_data[u] = d;
    @(posedge clk);
    #1;
    mem_read[u]  = 1'b0;
    mem_write[u] = 1'b0;
    addr[u]      = a2;
    for (int k = 1; k <= 20; k++) begin
      if (busy[u])
        nb++;
      if (ready[u]) begin
        lat = k;
        e   = err[u];
        rdv = read_data[u];
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  bit          e;
  logic [31:0] rdv;
  int          nb;
  int          seen;
  logic [5:0]  pat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      mem_read[i]   = 1'b0;
      mem_write[i]  = 1'b0;
      addr[i]       = '0;
      write_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", read_data[0], 32'h0);
    chk("rst_flags", {29'd0, ready[0], busy[0], err[0]}, 32'h0);

    access(0, 0, 1, 32'h10, 32'h1111_1111, 32'h10, lat, e, rdv, nb);
    chk("pre_store_lat", lat, 2);
    access(0, 1, 0, 32'h10, 32'h0, 32'h10, lat, e, rdv, nb);
    chk("pre_load", rdv, 32'h1111_1111);

    @(negedge clk);
    mem_write[0]  = 1'b1;
    addr[0]       = 32'h10;
    write_data[0] = 32'h2222_2222;
    @(posedge clk);
    #1;
    mem_write[0] = 1'b0;
    chk("mid_wait_busy", {31'd0, busy[0]}, 32'h1);
    rst = 1'b1;
    #2;
    chk("rst_mid_rdata", read_data[0], 32'h0);
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (ready[0])
        seen++;
    end
    chk("rst_no_ready", seen, 0);
    access(0, 1, 0, 32'h10, 32'h0, 32'h10, lat, e, rdv, nb);
    chk("rst_drop_store", rdv, 32'h1111_1111);

    access(0, 0, 1, 32'h04, 32'hDEAD_BEEF, 32'h04, lat, e, rdv, nb);
    chk("st_lat", lat, 2);
    chk("st_busy", nb, 2);
    chk("st_err", {31'd0, e}, 32'h0);
    access(0, 1, 0, 32'h04, 32'h0, 32'h04, lat, e, rdv, nb);
    chk("ld_lat", lat, 2);
    chk("ld_busy", nb, 2);
    chk("ld_data", rdv, 32'hDEAD_BEEF);

    access(0, 1, 0, 32'h06, 32'h0, 32'h06, lat, e, rdv, nb);
    chk("mis_lat", lat, 2);
    chk("mis_err", {31'd0, e}, 32'h1);
    chk("mis_hold", rdv, 32'hDEAD_BEEF);

    access(0, 0, 1, 32'h000, 32'hA5A5_A5A5, 32'h000, lat, e, rdv, nb);
    access(0, 0, 1, 32'h400, 32'h1, 32'h400, lat, e, rdv, nb);
    chk("rng_err", {31'd0, e}, 32'h1);
    chk("rng_hold", rdv, 32'hDEAD_BEEF);
    access(0, 1, 0, 32'h000, 32'h0, 32'h000, lat, e, rdv, nb);
    chk("rng_nowrap", rdv, 32'hA5A5_A5A5);
    chk("rng_ok_err", {31'd0, e}, 32'h0);

    access(0, 0, 1, 32'h3FC, 32'h0BAD_F00D, 32'h3FC, lat, e, rdv, nb);
    chk("top_st_err", {31'd0, e}, 32'h0);
    access(0, 1, 0, 32'h3FC, 32'h0, 32'h3FC, lat, e, rdv, nb);
    chk("top_ld", rdv, 32'h0BAD_F00D);

    access(0, 0, 1, 32'h08, 32'h0808_0808, 32'h08, lat, e, rdv, nb);
    access(0, 1, 1, 32'h08, 32'hFFFF_FFFF, 32'h08, lat, e, rdv, nb);
    chk("cf_err", {31'd0, e}, 32'h1);
    access(0, 1, 0, 32'h08, 32'h0, 32'h08, lat, e, rdv, nb);
    chk("cf_kept", rdv, 32'h0808_0808);

    access(1, 0, 1, 32'h0C, 32'h0C0C_1234, 32'h0C, lat, e, rdv, nb);
    chk("l1_st_lat", lat, 1);
    chk("l1_st_busy", nb, 1);
    @(negedge clk);
    mem_read[1] = 1'b1;
    addr[1]     = 32'h0C;
    pat         = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      pat[k] = ready[1];
    end
    mem_read[1] = 1'b0;
    chk("l1_held_pat", {26'd0, pat}, 32'h15);
    chk("l1_held_data", read_data[1], 32'h0C0C_1234);
    repeat (2) @(posedge clk);
    #1;

    access(2, 0, 1, 32'h20, 32'hCAFE_F00D, 32'h20, lat, e, rdv, nb);
    chk("l3_st_lat", lat, 3);
    access(2, 0, 1, 32'h24, 32'h1234_5678, 32'h24, lat, e, rdv, nb);
    access(2, 1, 0, 32'h20, 32'h0, 32'h24, lat, e, rdv, nb);
    chk("l3_ld_lat", lat, 3);
    chk("l3_ld_busy", nb, 3);
    chk("l3_addr_ign", rdv, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
